// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter family.
package wrr_arbiter_pkg;

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   // A zero weight still grants one transaction per turn.
   function automatic int unsigned eff_w(input int unsigned w);
      return (w == 32'd0) ? 32'd1 : w;
   endfunction

   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 32'd1 == n) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning circularly from ptr.
module rr_pick #(
   parameter int unsigned N  = 8,
   parameter int unsigned LN = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [LN-1:0] ptr,
   output logic [LN-1:0] idx,
   output logic          found
);

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   rot;
   int unsigned    pos;

   always_comb begin
      req_dbl = {req, req};
      // Rotating the doubled vector puts ptr at bit 0, so a plain priority scan is circular.
      rot     = N'(req_dbl >> ptr);
      idx     = '0;
      found   = 1'b0;
      pos     = 32'd0;
      for (int unsigned i = 0; i < N; i++) begin
         if (rot[i] && !found) begin
            found = 1'b1;
            pos   = 32'(ptr) + i;
            if (pos >= N) pos = pos - N;
            idx   = LN'(pos);
         end
      end
   end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter holding each grant for a whole transaction,
// with an optional watchdog that reclaims stuck grants.
module wrr_arbiter
   import wrr_arbiter_pkg::*;
#(
   parameter int unsigned N   = 8,
   parameter int unsigned LN  = $clog2(N),
   parameter int unsigned WW  = 4,
   parameter int unsigned TMO = 0,
   parameter int unsigned TW  = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clk_en,
   input  logic [N-1:0]    req,
   input  logic [N*WW-1:0] weight,
   input  logic            done,
   output logic [LN-1:0]   grant,
   output logic [N-1:0]    grant_oh,
   output logic            grant_valid,
   output logic            req_any,
   output logic            timeout
);

   state_e          state_q, state_d;
   logic [LN-1:0]   ptr_q, ptr_d;
   logic [LN-1:0]   owner_q, owner_d;
   logic [LN-1:0]   grant_q, grant_d;
   logic [WW-1:0]   credit_q, credit_d;
   logic            timeout_q, timeout_d;

   logic [LN-1:0]   pick_idx;
   logic            pick_found;
   logic [WW-1:0]   w_sel;
   logic [WW-1:0]   credit_dec;
   logic            abort, release_c, forced, wd_exp;

   rr_pick #(
      .N  (N),
      .LN (LN)
   ) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   if (TMO > 0) begin : g_wdog
      logic [TW-1:0] wdog_q, wdog_d;

      always_comb begin
         wdog_d = wdog_q;
         if (clk_en) wdog_d = (state_q == StIdle) ? '0 : wdog_q + 1'b1;
      end

      always_ff @(posedge clk) begin
         if (!rst_n) wdog_q <= '0;
         else        wdog_q <= wdog_d;
      end

      assign wd_exp = (state_q == StBusy) && (wdog_q == TW'(TMO - 1));
   end else begin : g_no_wdog
      assign wd_exp = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         owner_q   <= '0;
         grant_q   <= '0;
         credit_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         grant_q   <= grant_d;
         credit_q  <= credit_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clk_en) begin
         unique case (state_q)
            StIdle:  if (pick_found) state_d = StBusy;
            StBusy:  if (release_c) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      abort      = ~req[owner_q];
      release_c  = done | abort | wd_exp;
      // Expiry coinciding with done/abort is an ordinary release.
      forced     = wd_exp & ~done & ~abort;
      credit_dec = forced ? '0 : credit_q - 1'b1;
      w_sel      = weight[pick_idx*WW +: WW];

      ptr_d     = ptr_q;
      owner_d   = owner_q;
      grant_d   = grant_q;
      credit_d  = credit_q;
      timeout_d = timeout_q;
      if (clk_en) begin
         timeout_d = 1'b0;
         if (state_q == StIdle && pick_found) begin
            grant_d = pick_idx;
            owner_d = pick_idx;
            if (!(pick_idx == owner_q && credit_q != '0)) credit_d = WW'(eff_w(32'(w_sel)));
         end else if (state_q == StBusy && release_c) begin
            credit_d  = credit_dec;
            timeout_d = forced;
            ptr_d     = (credit_dec == '0) ? LN'(wrap_inc(32'(owner_q), N)) : owner_q;
         end
      end
   end

   always_comb begin
      grant       = grant_q;
      grant_valid = (state_q == StBusy);
      grant_oh    = '0;
      if (state_q == StBusy) grant_oh[grant_q] = 1'b1;
      req_any     = |req;
      timeout     = (TMO > 0) ? timeout_q : 1'b0;
   end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: an N=8 and an N=5 instance without watchdog,
// and an N=8 instance with a 10-cycle watchdog.
module tb_wrr_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   logic       a_en, a_done, a_valid, a_any, a_tmo;
   logic [7:0] a_req, a_oh;
   logic [31:0] a_weight;
   logic [2:0] a_grant;

   logic       b_en, b_done, b_valid, b_any, b_tmo;
   logic [4:0] b_req, b_oh;
   logic [19:0] b_weight;
   logic [2:0] b_grant;

   logic       c_en, c_done, c_valid, c_any, c_tmo;
   logic [7:0] c_req, c_oh;
   logic [31:0] c_weight;
   logic [2:0] c_grant;

   wrr_arbiter #(.N(8), .WW(4), .TMO(0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .clk_en(a_en), .req(a_req), .weight(a_weight), .done(a_done),
      .grant(a_grant), .grant_oh(a_oh), .grant_valid(a_valid), .req_any(a_any), .timeout(a_tmo)
   );

   wrr_arbiter #(.N(5), .WW(4), .TMO(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .clk_en(b_en), .req(b_req), .weight(b_weight), .done(b_done),
      .grant(b_grant), .grant_oh(b_oh), .grant_valid(b_valid), .req_any(b_any), .timeout(b_tmo)
   );

   wrr_arbiter #(.N(8), .WW(4), .TMO(10)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .clk_en(c_en), .req(c_req), .weight(c_weight), .done(c_done),
      .grant(c_grant), .grant_oh(c_oh), .grant_valid(c_valid), .req_any(c_any), .timeout(c_tmo)
   );

   typedef struct {
      logic [7:0]  req;
      logic [31:0] weight;
      logic        done;
      logic        en;
      logic [2:0]  grant;
      logic        valid;
      logic [7:0]  oh;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [7:0] r, input logic [31:0] w, input logic d, input logic e,
                      input logic [2:0] g, input logic v, input logic [7:0] oh);
      vec_t t;
      t.req = r; t.weight = w; t.done = d; t.en = e; t.grant = g; t.valid = v; t.oh = oh;
      vecs.push_back(t);
   endtask

   initial begin
      int g_seq[8];
      int b_seq[4];
      logic [7:0] one;

      a_en = 1'b1; a_done = 1'b0; a_req = 8'hFF; a_weight = 32'h1111_1111;
      b_en = 1'b1; b_done = 1'b0; b_req = '0;    b_weight = 20'h11111;
      c_en = 1'b1; c_done = 1'b0; c_req = '0;    c_weight = 32'h1111_1111;

      // Rotation 0..7,0 with done one cycle after each grant; then a frozen cycle.
      for (int i = 0; i < 9; i++) begin
         one = 8'h01 << (i % 8);
         add(8'hFF, 32'h1111_1111, 1'b0, 1'b1, 3'(i % 8), 1'b1, one);
         add(8'hFF, 32'h1111_1111, 1'b1, 1'b1, 3'(i % 8), 1'b0, 8'h00);
      end
      add(8'hFF, 32'h1111_1111, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
      // Channel 2 weight 3, ptr starts at 1.
      g_seq = '{1, 2, 2, 2, 1, 2, 2, 2};
      for (int i = 0; i < 8; i++) begin
         one = 8'h01 << g_seq[i];
         add(8'h06, 32'h1111_1311, 1'b0, 1'b1, 3'(g_seq[i]), 1'b1, one);
         add(8'h06, 32'h1111_1311, 1'b1, 1'b1, 3'(g_seq[i]), 1'b0, 8'h00);
      end
      // Owner drops its request: abort release, pointer moves on.
      add(8'h06, 32'h1111_1311, 1'b0, 1'b1, 3'd1, 1'b1, 8'h02);
      add(8'h04, 32'h1111_1311, 1'b0, 1'b1, 3'd1, 1'b0, 8'h00);
      add(8'h04, 32'h1111_1311, 1'b0, 1'b1, 3'd2, 1'b1, 8'h04);
      add(8'h04, 32'h1111_1311, 1'b1, 1'b1, 3'd2, 1'b0, 8'h00);

      // Reset with all requests present.
      step();
      check("reset valid", 32'(a_valid), 32'd0);
      check("reset grant", 32'(a_grant), 32'd0);
      check("reset oh", 32'(a_oh), 32'd0);
      check("reset timeout", 32'(c_tmo), 32'd0);
      check("reset req_any", 32'(a_any), 32'd1);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         a_req = vecs[i].req; a_weight = vecs[i].weight;
         a_done = vecs[i].done; a_en = vecs[i].en;
         step();
         check($sformatf("A[%0d] valid", i), 32'(a_valid), 32'(vecs[i].valid));
         check($sformatf("A[%0d] grant", i), 32'(a_grant), 32'(vecs[i].grant));
         check($sformatf("A[%0d] oh", i), 32'(a_oh), 32'(vecs[i].oh));
      end
      a_req = '0; a_done = 1'b0;

      // N=5: pointer wraps 4 -> 0.
      b_req = 5'b10001;
      b_seq = '{0, 4, 0, 4};
      for (int i = 0; i < 4; i++) begin
         b_done = 1'b0;
         step();
         check($sformatf("B[%0d] valid", i), 32'(b_valid), 32'd1);
         check($sformatf("B[%0d] grant", i), 32'(b_grant), 32'(b_seq[i]));
         b_done = 1'b1;
         step();
         check($sformatf("B[%0d] release", i), 32'(b_valid), 32'd0);
      end
      b_req = '0; b_done = 1'b0;

      // Watchdog: lone requester 3 regains the grant after a forced release.
      c_req = 8'h08;
      step();
      check("C grant", 32'(c_grant), 32'd3);
      for (int j = 1; j <= 10; j++) begin
         step();
         check($sformatf("C tmo %0d", j), 32'(c_tmo), (j == 10) ? 32'd1 : 32'd0);
         check($sformatf("C valid %0d", j), 32'(c_valid), (j == 10) ? 32'd0 : 32'd1);
      end
      step();
      check("C regrant tmo", 32'(c_tmo), 32'd0);
      check("C regrant valid", 32'(c_valid), 32'd1);
      check("C regrant grant", 32'(c_grant), 32'd3);
      // A second requester appears: after timeout it wins over 3.
      c_req = 8'h28;
      for (int j = 1; j <= 10; j++) step();
      check("C2 tmo", 32'(c_tmo), 32'd1);
      step();
      check("C2 next grant", 32'(c_grant), 32'd5);
      check("C2 next valid", 32'(c_valid), 32'd1);

      // Reset mid-transaction.
      rst_n = 1'b0;
      step();
      check("C midreset valid", 32'(c_valid), 32'd0);
      check("C midreset tmo", 32'(c_tmo), 32'd0);
      rst_n = 1'b1;

      // clk_en toggling: 10 enabled cycles span 20 clocks; done in a disabled cycle is ignored.
      c_req = 8'h08;
      step();
      check("CE grant", 32'(c_valid), 32'd1);
      for (int k = 1; k <= 20; k++) begin
         c_en = (k % 2 == 0);
         c_done = (k == 5);
         step();
         check($sformatf("CE tmo %0d", k), 32'(c_tmo), (k == 20) ? 32'd1 : 32'd0);
         check($sformatf("CE valid %0d", k), 32'(c_valid), (k == 20) ? 32'd0 : 32'd1);
      end
      c_done = 1'b0;
      c_en = 1'b0;
      step();
      check("CE tmo held", 32'(c_tmo), 32'd1);
      c_en = 1'b1;
      step();
      check("CE tmo clear", 32'(c_tmo), 32'd0);
      check("CE regrant", 32'(c_valid), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
